// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder -- bit-serial WIDTH-bit adder, LSB first.
//
// A full adder made of two half-adder cells (ha) plus an OR gate handles one
// operand bit pair per clock. The carry is kept in a register between bits.
// Operands are captured on an accepted start. WIDTH shift cycles follow, and
// then one DONE cycle in which the registered sum/co are presented.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset (priority over start)
//   start  in   1      load request, sampled only in IDLE
//   a, b   in   WIDTH  operands, captured on the accepted start edge
//   busy   out  1      high in SHIFT and DONE (state decoded)
//   done   out  1      one-cycle strobe; sum/co valid from this cycle
//   sum    out  WIDTH  (a+b) mod 2^WIDTH, registered
//   co     out  1      carry out of bit WIDTH-1, registered
// -----------------------------------------------------------------------------

// Half-adder cell: sum and carry of two bits.
module ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] s_sr_r;
    logic             cy_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       state_r;

    logic p_s;
    logic g0_s;
    logic s_s;
    logic g1_s;
    logic cout_s;

    // Full adder on the current LSB pair and the stored carry.
    ha u_ha0 (.x(a_sr_r[0]), .y(b_sr_r[0]), .s(p_s), .c(g0_s));
    ha u_ha1 (.x(p_s),       .y(cy_r),      .s(s_s), .c(g1_s));
    assign cout_s = g0_s | g1_s;

    // Moore outputs decoded from the state register only.
    assign busy = (state_r == SHIFT) || (state_r == DONE);
    assign done = (state_r == DONE);

    // Control FSM, shift datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sr_r  <= {WIDTH{1'b0}};
            b_sr_r  <= {WIDTH{1'b0}};
            s_sr_r  <= {WIDTH{1'b0}};
            cy_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum     <= {WIDTH{1'b0}};
            co      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        s_sr_r  <= {WIDTH{1'b0}};
                        cy_r    <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
                    s_sr_r <= {s_s, s_sr_r[WIDTH-1:1]};
                    cy_r   <= cout_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    // Last bit: publish the completed word directly, since
                    // s_sr_r itself only catches up one edge later.
                    if (cnt_r == CNT_LAST) begin
                        sum     <= {s_s, s_sr_r[WIDTH-1:1]};
                        co      <= cout_s;
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder -- directed tests for serial_adder at WIDTH=8, plus an
// exhaustive back-to-back sweep on a second instance at WIDTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8, sum8;
    logic [3:0] a4, b4, sum4;
    logic       busy8, done8, co8;
    logic       busy4, done4, co4;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .co(co8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .co(co4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The current cycle (index 0) carries start; returns in the done cycle.
    // Operand inputs are scrambled after acceptance to prove they were captured.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input bit chk_hold, input logic [7:0] hs, input logic hc,
                        output int lat, output int bcyc);
        a8 = av; b8 = bv; start8 = 1'b1;
        lat = 0; bcyc = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            start8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (busy8) bcyc++;
            if (done8) begin
                lat = c;
                break;
            end
            if (chk_hold) begin
                vectors++;
                if (sum8 !== hs || co8 !== hc) begin
                    errors++;
                    $display("FAIL hold cycle %0d: sum=%h co=%b, required sum=%h co=%b", c, sum8, co8, hs, hc);
                end
            end
        end
        if (lat == 0) begin
            vectors++;
            errors++;
            $display("FAIL run8_timeout a=%h b=%h: no done within 30 cycles, required done", av, bv);
        end
    endtask

    task automatic check_result8(input string name, input logic [7:0] es, input logic ec);
        vectors++;
        if (sum8 !== es || co8 !== ec) begin
            errors++;
            $display("FAIL %s: sum=%h co=%b, required sum=%h co=%b", name, sum8, co8, es, ec);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({busy8, done8, co8, sum8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b co=%b sum=%h, required all 0", busy8, done8, co8, sum8);
        end
        vectors++;
        if ({busy4, done4, co4, sum4} !== 7'd0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b co=%b sum=%h, required all 0", busy4, done4, co4, sum4);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy8, done8);
        end
    endtask

    task automatic test_basic();
        int lat, bcyc;
        run8(8'd3, 8'd5, 1'b0, 8'd0, 1'b0, lat, bcyc);
        // Start cycle is index 0: 8 SHIFT cycles, then DONE at index 9.
        vectors++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: done at cycle %0d, required 9", lat);
        end
        vectors++;
        if (bcyc !== 9) begin
            errors++;
            $display("FAIL basic_busy_cycles: %0d, required 9", bcyc);
        end
        check_result8("basic_3p5", 8'd8, 1'b0);
        step();
        vectors++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_one_cycle: busy=%b done=%b, required 0 0", busy8, done8);
        end
        check_result8("basic_hold_after_done", 8'd8, 1'b0);
    endtask

    task automatic test_overflow();
        int lat, bcyc;
        run8(8'hFF, 8'h01, 1'b0, 8'd0, 1'b0, lat, bcyc);
        check_result8("ovf_ff_01", 8'h00, 1'b1);
        step();
        run8(8'hFF, 8'hFF, 1'b0, 8'd0, 1'b0, lat, bcyc);
        check_result8("ovf_ff_ff", 8'hFE, 1'b1);
        step();
    endtask

    task automatic test_zero_hold();
        int lat, bcyc;
        run8(8'hAA, 8'h55, 1'b0, 8'd0, 1'b0, lat, bcyc);
        check_result8("alt_aa_55", 8'hFF, 1'b0);
        step();
        run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, lat, bcyc);
        check_result8("zero_add", 8'h00, 1'b0);
        step();
    endtask

    task automatic test_start_while_busy();
        int ndone = 0;
        int done_at = 0;
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (c == 3 || c == 9) begin
                start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                ndone++;
                done_at = c;
            end
        end
        vectors++;
        if (ndone !== 1 || done_at !== 9) begin
            errors++;
            $display("FAIL busy_start_done: count=%0d at cycle %0d, required 1 at 9", ndone, done_at);
        end
        check_result8("busy_start_sum", 8'h30, 1'b0);
        vectors++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_no_second_op: busy=%b, required 0", busy8);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcyc;
        int ndone = 0;
        a8 = 8'h7F; b8 = 8'h01; start8 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            start8 = 1'b0;
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({busy8, done8, co8, sum8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b co=%b sum=%h, required all 0", busy8, done8, co8, sum8);
        end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done8) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: %0d strobes, required 0", ndone);
        end
        run8(8'h02, 8'h03, 1'b0, 8'd0, 1'b0, lat, bcyc);
        check_result8("after_reset_2p3", 8'h05, 1'b0);
        step();
    endtask

    // Every operand pair at WIDTH=4, each start in the first IDLE cycle after done.
    task automatic test_back_to_back();
        logic [4:0] exp5;
        int lat;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a4 = 4'(ai); b4 = 4'(bi); start4 = 1'b1;
                exp5 = 5'(ai + bi);
                lat = 0;
                for (int c = 1; c <= 20; c++) begin
                    step();
                    start4 = 1'b0;
                    if (done4) begin
                        lat = c;
                        break;
                    end
                end
                vectors++;
                if (lat !== 5) begin
                    errors++;
                    $display("FAIL b2b_latency a=%0d b=%0d: done at %0d, required 5", ai, bi, lat);
                end
                vectors++;
                if ({co4, sum4} !== exp5) begin
                    errors++;
                    $display("FAIL b2b_sum a=%0d b=%0d: co,sum=%h, required %h", ai, bi, {co4, sum4}, exp5);
                end
                step();
                vectors++;
                if (busy4 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle a=%0d b=%0d: busy=%b, required 0", ai, bi, busy4);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; start4 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; a4 = 4'd0; b4 = 4'd0;
        test_reset();
        test_basic();
        test_overflow();
        test_zero_hold();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
